vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the scan-out pixel fetcher (video) and a host write/read port.
- Sits between the frame/pattern generation logic and the VRAM macro, all in the clk40 domain.
- Video has priority so scan-out never misses a word. The host is served in idle slots.
- One access is in flight at a time, sequenced by a small FSM.

Parameters:
- ADDR_W, 15, VRAM word address width.
- DATA_W, 16, VRAM word width.
- MEM_LAT, 1, VRAM read latency in cycles from the mem_en cycle to valid mem_rdata (legal range 1..7).
- STARVE_MAX, 8, consecutive lost arbitrations before the host is forced a slot (used only with the optional feature).

Ports:
- clk40  in  1  system pixel clock; all state clocked on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- vid_req  in  1  video fetch request; level, held until vid_ack.
- vid_addr  in  ADDR_W  video fetch address; stable while vid_req is high.
- vid_ack  out  1  one-cycle pulse; vid_rdata is valid in the same cycle.
- vid_rdata  out  DATA_W  fetched word; holds its value until the next video read completes.
- host_req  in  1  host request; level, held until host_ack.
- host_we  in  1  1 = write, 0 = read; stable while host_req is high.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DATA_W  host read word; holds its value until the next host read completes.
- mem_en  out  1  VRAM access strobe, one cycle per access.
- mem_we  out  1  VRAM write enable; only meaningful when mem_en is high.
- mem_addr  out  ADDR_W  VRAM address.
- mem_wdata  out  DATA_W  VRAM write data.
- mem_rdata  in  DATA_W  VRAM read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - FSM goes to IDLE.
  - All outputs go to 0, including vid_rdata, host_rdata, mem_addr and mem_wdata.
  - Starve counter is cleared.
  - An access in progress is abandoned: no ack is issued and the requester re-requests.
- FSM states are IDLE, ACCESS, WAIT and DONE.
- IDLE:
  - If vid_req is high, grant video. Otherwise, if host_req is high, grant the host. Otherwise stay in IDLE.
  - On a grant, latch the owner plus addr/we/wdata into registers and go to ACCESS.
- ACCESS (1 cycle):
  - mem_en = 1. mem_we = owner is host AND host_we. mem_addr and mem_wdata come from the latched registers.
  - Go to WAIT with the latency counter loaded to MEM_LAT.
- WAIT:
  - Count down. On the last cycle (MEM_LAT cycles after ACCESS), register mem_rdata into the owner's rdata register (reads only).
  - Then go to DONE.
- DONE (1 cycle):
  - Pulse the owner's ack. Go to IDLE.
- Cycle timing with MEM_LAT = 1 and the request seen in IDLE at cycle 0:
  - mem_en at cycle 1.
  - rdata captured at the end of cycle 2.
  - ack at cycle 3.
  - Back in IDLE at cycle 4.
  - One access every MEM_LAT + 3 cycles.
- Requester obligation: drop req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Simultaneous vid_req and host_req in IDLE: video wins.
- A request that arrives while busy waits. It is evaluated at the next IDLE.
- Host writes do not modify host_rdata. vid_rdata is never modified by host accesses, and host_rdata is never modified by video accesses.
- mem_en is never high for two consecutive cycles.
- Outside ACCESS, mem_en = 0 and mem_we = 0.
- mem_addr and mem_wdata hold their last value when idle.

Optional Feature:
- Macro: VRAM_HOST_STARVE_GUARD_EN.
- When defined:
  - A saturating counter increments each time the host is pending in IDLE and loses to video.
  - It clears when the host is granted.
  - When the counter equals STARVE_MAX, the host wins the next IDLE arbitration even if vid_req is high.
- When undefined: strict video priority; the counter logic is absent.

Test Plan:
- Video read only: preload addr 0x0010 = 0xBEEF, MEM_LAT = 1, vid_req at cycle 0 with vid_addr = 0x0010 -> mem_en at cycle 1 with mem_addr = 0x0010 and mem_we = 0; vid_ack at cycle 3 with vid_rdata = 0xBEEF; host_ack stays 0.
- Host write then read: write 0x1234 to 0x0100, then read 0x0100 -> write shows mem_en = 1, mem_we = 1, mem_wdata = 0x1234, then host_ack; read returns host_rdata = 0x1234 with host_ack; vid_rdata unchanged.
- Simultaneous requests: vid_req and host_req rise together -> video is served first (vid_ack at cycle 3); the host is granted at cycle 4 and host_ack comes at cycle 7.
- Reset mid-operation: assert reset_n = 0 during WAIT -> all outputs are 0 immediately; no ack pulse is ever seen for that request; after release the held req is re-served normally.
- MEM_LAT = 3 build: video read -> mem_en at cycle 1, rdata captured at cycle 4, ack at cycle 5; busy is high from cycle 1 through cycle 5.
- With VRAM_HOST_STARVE_GUARD_EN and STARVE_MAX = 2: hold vid_req continuously and host_req high -> exactly 2 video accesses, then 1 host access, then video resumes. Without the macro, host_ack never occurs while vid_req stays high.

Source files
------------

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous VRAM between the scan-out fetcher (priority) and a host port.
// Define VRAM_HOST_STARVE_GUARD_EN to force a host slot after STARVE_MAX lost arbitrations.
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk40,
  input  logic              reset_n,

  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,

  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  state_e state_q, state_d;

  logic              owner_q, owner_d;  // 1 = host, 0 = video
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        lat_q, lat_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  logic grant_vid, grant_host;
  logic host_forced;

`ifdef VRAM_HOST_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_q, starve_d;

  assign host_forced = (starve_q == CntW'(STARVE_MAX));

  // A video grant with host pending only happens below STARVE_MAX, so the count saturates there.
  always_comb begin
    starve_d = starve_q;
    if (grant_host) begin
      starve_d = '0;
    end else if (grant_vid && host_req) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_max;

  assign host_forced       = 1'b0;
  assign unused_starve_max = ^STARVE_MAX;
`endif

  // Arbitration is only evaluated in IDLE; video wins unless the host is being forced.
  always_comb begin
    grant_vid  = 1'b0;
    grant_host = 1'b0;
    if (state_q == StIdle) begin
      if (host_req && (!vid_req || host_forced)) begin
        grant_host = 1'b1;
      end else if (vid_req) begin
        grant_vid = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (grant_vid || grant_host) state_d = StAccess;
      StAccess: state_d = StWait;
      StWait:   if (lat_q == 3'd1) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = (state_q != StIdle);
    mem_en   = (state_q == StAccess);
    mem_we   = (state_q == StAccess) && we_q;
    vid_ack  = (state_q == StDone) && !owner_q;
    host_ack = (state_q == StDone) && owner_q;
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign vid_rdata  = vid_rdata_q;
  assign host_rdata = host_rdata_q;

  // Request latch, latency countdown and read-data capture
  always_comb begin
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lat_d        = lat_q;
    vid_rdata_d  = vid_rdata_q;
    host_rdata_d = host_rdata_q;

    if (grant_host) begin
      owner_d = 1'b1;
      we_d    = host_we;
      addr_d  = host_addr;
      wdata_d = host_wdata;
    end else if (grant_vid) begin
      owner_d = 1'b0;
      we_d    = 1'b0;
      addr_d  = vid_addr;
    end

    if (state_q == StAccess) begin
      lat_d = 3'(MEM_LAT);
    end else if (state_q == StWait) begin
      lat_d = lat_q - 3'd1;
    end

    // Last WAIT cycle is exactly MEM_LAT cycles after the strobe, when mem_rdata is valid.
    if ((state_q == StWait) && (lat_q == 3'd1) && !we_q) begin
      if (owner_q) begin
        host_rdata_d = mem_rdata;
      end else begin
        vid_rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lat_q        <= '0;
      vid_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lat_q        <= lat_d;
      vid_rdata_q  <= vid_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed vector table, corner sequences and a
// randomized run against a transaction-slot reference model.
module tb_vram_arbiter;

  localparam int LAT = 1;
  localparam int SM  = 2;
  localparam int P   = LAT + 3;

  logic        clk40 = 1'b0;
  logic        reset_n = 1'b1;
  logic        vid_req, host_req, host_we;
  logic [14:0] vid_addr, host_addr, mem_addr;
  logic [15:0] host_wdata, vid_rdata, host_rdata, mem_wdata, mem_rdata;
  logic        vid_ack, host_ack, mem_en, mem_we, busy;

  int n_checks = 0;
  int n_fail   = 0;

  vram_arbiter #(
    .ADDR_W    (15),
    .DATA_W    (16),
    .MEM_LAT   (LAT),
    .STARVE_MAX(SM)
  ) u_dut (
    .clk40     (clk40),
    .reset_n   (reset_n),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_ack   (vid_ack),
    .vid_rdata (vid_rdata),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_ack  (host_ack),
    .host_rdata(host_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial forever #5 clk40 = ~clk40;

  function automatic logic [15:0] init_word(input logic [14:0] a);
    return (a == 15'h0010) ? 16'hBEEF : {a[7:0], ~a[7:0]};
  endfunction

  // VRAM macro: read data appears LAT cycles after the strobe, junk otherwise.
  logic [15:0] vram    [32768];
  logic [15:0] ref_mem [32768];
  logic [15:0] rd_pipe [8];
  logic        vram_loaded = 1'b0;

  always @(posedge clk40) begin
    if (!vram_loaded) begin
      for (int i = 0; i < 32768; i++) vram[i] <= init_word(15'(i));
      vram_loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      vram[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? vram[mem_addr] : 16'($urandom);
    for (int i = 1; i < 8; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[LAT-1];

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk40);
    #1;
  endtask

  typedef struct {
    logic        host;
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  // One isolated transaction; cycle 0 is the IDLE cycle that sees the request.
  task automatic run_txn(input vec_t v);
    logic [15:0] vid_rd0, host_rd0;
    vid_rd0  = vid_rdata;
    host_rd0 = host_rdata;
    if (v.host) begin
      host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
    end else begin
      vid_req = 1'b1; vid_addr = v.addr;
    end
    for (int c = 0; c <= P; c++) begin
      @(negedge clk40);
      chk_b("txn_busy", busy, (c >= 1) && (c <= LAT + 2));
      chk_b("txn_mem_en", mem_en, c == 1);
      if (c == 1) begin
        chk_b("txn_mem_we", mem_we, v.host && v.we);
        chk_w("txn_mem_addr", 32'(mem_addr), 32'(v.addr));
        if (v.host && v.we) chk_w("txn_mem_wdata", 32'(mem_wdata), 32'(v.wdata));
      end
      chk_b("txn_vid_ack", vid_ack, (c == LAT + 2) && !v.host);
      chk_b("txn_host_ack", host_ack, (c == LAT + 2) && v.host);
      if (c == LAT + 2) begin
        chk_w("txn_vid_rdata", 32'(vid_rdata), 32'(v.host ? vid_rd0 : v.exp_rdata));
        chk_w("txn_host_rdata", 32'(host_rdata),
              32'((v.host && !v.we) ? v.exp_rdata : host_rd0));
      end
      if (c == P) chk_w("txn_addr_hold", 32'(mem_addr), 32'(v.addr));
      tick();
      if (c == LAT + 2) begin
        vid_req  = 1'b0;
        host_req = 1'b0;
      end
    end
    if (v.host && v.we) ref_mem[v.addr] = v.wdata;
  endtask

  task automatic simultaneous_test();
    vid_req = 1'b1; vid_addr = 15'h0010;
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0100;
    for (int c = 0; c <= 2 * P; c++) begin
      @(negedge clk40);
      chk_b("sim_vid_ack", vid_ack, c == LAT + 2);
      chk_b("sim_host_ack", host_ack, c == P + LAT + 2);
      chk_b("sim_mem_en", mem_en, (c == 1) || (c == P + 1));
      if (c == 1) chk_w("sim_addr_vid", 32'(mem_addr), 32'h0010);
      if (c == P + 1) chk_w("sim_addr_host", 32'(mem_addr), 32'h0100);
      if (c == LAT + 2) chk_w("sim_vid_rdata", 32'(vid_rdata), 32'hBEEF);
      if (c == P + LAT + 2) chk_w("sim_host_rdata", 32'(host_rdata), 32'h1234);
      tick();
      if (c == LAT + 2) vid_req = 1'b0;
      if (c == P + LAT + 2) host_req = 1'b0;
    end
  endtask

  // Video held for six slots with the host pending from the start.
  task automatic starve_test();
    int host_slot;
`ifdef VRAM_HOST_STARVE_GUARD_EN
    host_slot = SM;
`else
    host_slot = 6;
`endif
    vid_req = 1'b1; vid_addr = 15'h0010;
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0100;
    for (int c = 0; c < 7 * P; c++) begin
      logic exp_v, exp_h;
      exp_v = (c % P == LAT + 2) && (c / P < 6) && (c / P != host_slot);
      exp_h = (c % P == LAT + 2) && (c / P == host_slot);
      @(negedge clk40);
      chk_b("starve_vid_ack", vid_ack, exp_v);
      chk_b("starve_host_ack", host_ack, exp_h);
      tick();
      if (c + 1 == 6 * P) vid_req = 1'b0;
      if (exp_h) host_req = 1'b0;
    end
  endtask

  task automatic reset_test();
    bit seen;
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0100;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk_b("rstmid_busy", busy, 1'b0);
    chk_b("rstmid_mem_en", mem_en, 1'b0);
    chk_b("rstmid_mem_we", mem_we, 1'b0);
    chk_b("rstmid_host_ack", host_ack, 1'b0);
    chk_w("rstmid_vid_rdata", 32'(vid_rdata), 32'h0);
    chk_w("rstmid_host_rdata", 32'(host_rdata), 32'h0);
    chk_w("rstmid_mem_addr", 32'(mem_addr), 32'h0);
    chk_w("rstmid_mem_wdata", 32'(mem_wdata), 32'h0);
    repeat (3) begin
      @(negedge clk40);
      chk_b("rsthold_host_ack", host_ack, 1'b0);
    end
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 4 * P && !seen; k++) begin
      tick();
      @(negedge clk40);
      if (host_ack) begin
        seen = 1'b1;
        chk_w("rst_reserve_cycle", 32'(k), 32'(LAT + 2));
        chk_w("rst_reserve_rdata", 32'(host_rdata), 32'h1234);
      end
    end
    chk_b("rst_reserve_ack", seen, 1'b1);
    tick();
    host_req = 1'b0;
  endtask

  // Reference model: each grant books a slot of P cycles starting at the IDLE cycle t0;
  // the strobe lands at t0+1 and the ack at t0+LAT+2.
  task automatic random_phase(input int n_cycles);
    bit          act = 0, own_h = 0, m_we = 0, hwin, e_en, e_busy, e_vack = 0, e_hack = 0;
    int          t0 = 0, rel;
    logic [14:0] m_addr = '0, e_maddr = '0;
    logic [15:0] m_wdata = '0, m_rd = '0, e_vrd = '0, e_hrd = '0;
`ifdef VRAM_HOST_STARVE_GUARD_EN
    int          lost = 0;
`endif
    reset_n = 1'b0;
    tick();
    tick();
    @(negedge clk40);
    reset_n = 1'b1;
    tick();
    for (int t = 0; t < n_cycles; t++) begin
      if (e_vack) vid_req = 1'b0;
      else if (!vid_req && $urandom_range(0, 2) == 0) begin
        vid_req  = 1'b1;
        vid_addr = 15'($urandom_range(0, 63));
      end
      if (e_hack) host_req = 1'b0;
      else if (!host_req && $urandom_range(0, 3) == 0) begin
        host_req   = 1'b1;
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 15'($urandom_range(0, 63));
        host_wdata = 16'($urandom);
      end

      if (act && (t - t0 == P)) act = 0;
      if (!act && (vid_req || host_req)) begin
        hwin = host_req && !vid_req;
`ifdef VRAM_HOST_STARVE_GUARD_EN
        if (host_req && lost == SM) hwin = 1;
        if (hwin) lost = 0;
        else if (host_req) lost = (lost < SM) ? lost + 1 : lost;
`endif
        act     = 1;
        t0      = t;
        own_h   = hwin;
        m_we    = hwin && host_we;
        m_addr  = hwin ? host_addr : vid_addr;
        m_wdata = host_wdata;
      end
      rel  = act ? t - t0 : 0;
      e_en = act && (rel == 1);
      if (e_en) begin
        e_maddr = m_addr;
        if (m_we) ref_mem[m_addr] = m_wdata;
        else m_rd = ref_mem[m_addr];
      end
      e_vack = act && (rel == LAT + 2) && !own_h;
      e_hack = act && (rel == LAT + 2) && own_h;
      if (e_vack && !m_we) e_vrd = m_rd;
      if (e_hack && !m_we) e_hrd = m_rd;
      e_busy = act && (rel >= 1);

      @(negedge clk40);
      chk_b("rnd_busy", busy, e_busy);
      chk_b("rnd_mem_en", mem_en, e_en);
      chk_b("rnd_mem_we", mem_we, e_en && m_we);
      chk_w("rnd_mem_addr", 32'(mem_addr), 32'(e_maddr));
      if (e_en && m_we) chk_w("rnd_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk_b("rnd_vid_ack", vid_ack, e_vack);
      chk_b("rnd_host_ack", host_ack, e_hack);
      chk_w("rnd_vid_rdata", 32'(vid_rdata), 32'(e_vrd));
      chk_w("rnd_host_rdata", 32'(host_rdata), 32'(e_hrd));
      tick();
    end
    vid_req  = 1'b0;
    host_req = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    vid_req = 1'b0; host_req = 1'b0; host_we = 1'b0;
    vid_addr = '0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(15'(i));

    vecs[0] = '{host: 1'b0, we: 1'b0, addr: 15'h0010, wdata: 16'h0000, exp_rdata: 16'hBEEF};
    vecs[1] = '{host: 1'b1, we: 1'b1, addr: 15'h0100, wdata: 16'h1234, exp_rdata: 16'h0000};
    vecs[2] = '{host: 1'b1, we: 1'b0, addr: 15'h0100, wdata: 16'hAAAA, exp_rdata: 16'h1234};
    vecs[3] = '{host: 1'b0, we: 1'b0, addr: 15'h0100, wdata: 16'h0000, exp_rdata: 16'h1234};
    vecs[4] = '{host: 1'b1, we: 1'b0, addr: 15'h0010, wdata: 16'h5555, exp_rdata: 16'hBEEF};
    vecs[5] = '{host: 1'b1, we: 1'b1, addr: 15'h7FFF, wdata: 16'hFFFF, exp_rdata: 16'h0000};
    vecs[6] = '{host: 1'b0, we: 1'b0, addr: 15'h7FFF, wdata: 16'h0000, exp_rdata: 16'hFFFF};
    vecs[7] = '{host: 1'b1, we: 1'b0, addr: 15'h0000, wdata: 16'h0000, exp_rdata: 16'h00FF};

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk40);
    #1;
    chk_b("reset_busy", busy, 1'b0);
    chk_b("reset_mem_en", mem_en, 1'b0);
    chk_b("reset_mem_we", mem_we, 1'b0);
    chk_b("reset_vid_ack", vid_ack, 1'b0);
    chk_b("reset_host_ack", host_ack, 1'b0);
    chk_w("reset_vid_rdata", 32'(vid_rdata), 32'h0);
    chk_w("reset_host_rdata", 32'(host_rdata), 32'h0);
    chk_w("reset_mem_addr", 32'(mem_addr), 32'h0);
    chk_w("reset_mem_wdata", 32'(mem_wdata), 32'h0);
    @(negedge clk40);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);
    simultaneous_test();
    starve_test();
    reset_test();
    random_phase(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
